// File: rtl/packet_transmitter.sv
// RMII transmit framer: preamble/SFD, MAC header, payload, zero pad and CRC-32 FCS,
// one dibit per 50 MHz clock, followed by the inter-packet gap.
module packet_transmitter #(
    parameter int          MII_WIDTH   = 2,
    parameter logic [47:0] SRC_MAC     = 48'he86a64e7e830,
    parameter logic [47:0] DEST_MAC    = 48'hffffffffffff,
    parameter int          MIN_PAYLOAD = 46,
    parameter int          MAX_PAYLOAD = 1500,
    parameter int          IFG_BYTES   = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [15:0]          length,
    output logic                 busy,
    input  logic [31:0]          data,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic                 underrun,
    output logic [MII_WIDTH-1:0] txd,
    output logic                 tx_en
);
    localparam logic [15:0] MIN_LEN  = 16'(MIN_PAYLOAD);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_PAYLOAD);
    localparam logic [15:0] IFG_LAST = 16'(IFG_BYTES - 1);
    localparam logic [31:0] POLY     = 32'hEDB88320;

    typedef enum logic [2:0] {
        S_IDLE, S_PREAMBLE, S_HEADER, S_PAYLOAD, S_PAD, S_FCS, S_IFG
    } state_t;

    state_t                state_q, state_d, state_after;
    logic [15:0]           byte_q, len_q, words_q, words_d, byte_last;
    logic [1:0]            dib_q, dibit;
    logic [31:0]           crc_q, sh_q, hold_q, eff_sh;
    logic [4:0]            sh_dib_q;
    logic                  hold_vld_q, hold_vld_d;
    logic                  busy_q, data_ready_q, data_ready_d, underrun_q, tx_en_q;
    logic [MII_WIDTH-1:0]  txd_q;
    logic                  accept, xfer, need_load, urun, byte_end;
    logic [111:0]          hdr_vec;
    logic [6:0]            hdr_shamt;
    logic [7:0]            hdr_byte;

    function automatic logic [31:0] crc_dibit(input logic [31:0] c, input logic [1:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 2; i++)
            r = (r[0] ^ d[i]) ? ((r >> 1) ^ POLY) : (r >> 1);
        return r;
    endfunction

    always_comb begin
        accept    = (state_q == S_IDLE) && !busy_q && start && (length <= MAX_LEN);
        xfer      = data_valid && data_ready_q;
        need_load = (state_q == S_PAYLOAD) && (sh_dib_q == 5'd0);
        // A word arriving on the very boundary that needs it is used directly.
        urun      = need_load && !hold_vld_q && !xfer;
        eff_sh    = !need_load ? sh_q : (hold_vld_q ? hold_q : data);

        hdr_vec   = {DEST_MAC, SRC_MAC, len_q};
        hdr_shamt = 7'd104 - {byte_q[3:0], 3'b000};
        hdr_byte  = 8'(hdr_vec >> hdr_shamt);

        dibit = 2'b00;
        case (state_q)
            S_PREAMBLE: dibit = (byte_q == 16'd7 && dib_q == 2'd3) ? 2'b11 : 2'b01;
            S_HEADER:   dibit = 2'(hdr_byte >> {dib_q, 1'b0});
            S_PAYLOAD:  dibit = eff_sh[1:0];
            S_FCS:      dibit = ~crc_q[1:0];
            default:    dibit = 2'b00;
        endcase

        byte_last = 16'd0;
        case (state_q)
            S_PREAMBLE: byte_last = 16'd7;
            S_HEADER:   byte_last = 16'd13;
            S_PAYLOAD:  byte_last = len_q - 16'd1;
            S_PAD:      byte_last = MIN_LEN - len_q - 16'd1;
            S_FCS:      byte_last = 16'd3;
            S_IFG:      byte_last = IFG_LAST;
            default:    byte_last = 16'd0;
        endcase
        byte_end = (dib_q == 2'd3) && (byte_q == byte_last);

        state_after = S_IDLE;
        case (state_q)
            S_PREAMBLE: state_after = S_HEADER;
            S_HEADER:   state_after = (len_q != 16'd0) ? S_PAYLOAD :
                                      ((len_q < MIN_LEN) ? S_PAD : S_FCS);
            S_PAYLOAD:  state_after = (len_q < MIN_LEN) ? S_PAD : S_FCS;
            S_PAD:      state_after = S_FCS;
            S_FCS:      state_after = S_IFG;
            default:    state_after = S_IDLE;
        endcase

        state_d = state_q;
        if (state_q == S_IDLE) begin
            if (accept) state_d = S_PREAMBLE;
        end else if (urun) begin
            state_d = S_IFG;
        end else if (byte_end) begin
            state_d = state_after;
        end

        hold_vld_d = hold_vld_q;
        if (need_load && hold_vld_q) hold_vld_d = 1'b0;
        else if (xfer && !need_load)  hold_vld_d = 1'b1;
        words_d      = words_q - {15'd0, xfer};
        data_ready_d = (state_d == S_HEADER || state_d == S_PAYLOAD) &&
                       !hold_vld_d && (words_d != 16'd0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            byte_q       <= '0;
            dib_q        <= '0;
            len_q        <= '0;
            words_q      <= '0;
            crc_q        <= '1;
            sh_q         <= '0;
            sh_dib_q     <= '0;
            hold_q       <= '0;
            hold_vld_q   <= 1'b0;
            busy_q       <= 1'b0;
            data_ready_q <= 1'b0;
            underrun_q   <= 1'b0;
            tx_en_q      <= 1'b0;
            txd_q        <= '0;
        end else begin
            state_q      <= state_d;
            data_ready_q <= data_ready_d;
            underrun_q   <= urun;
            if (state_q == S_IDLE) begin
                busy_q  <= accept;
                tx_en_q <= 1'b0;
                txd_q   <= '0;
                if (accept) begin
                    byte_q     <= '0;
                    dib_q      <= '0;
                    len_q      <= length;
                    words_q    <= (length + 16'd3) >> 2;
                    crc_q      <= '1;
                    sh_dib_q   <= '0;
                    hold_vld_q <= 1'b0;
                end
            end else begin
                busy_q     <= 1'b1;
                hold_vld_q <= hold_vld_d;
                words_q    <= words_d;
                if (xfer && !need_load) hold_q <= data;
                if (urun) begin
                    tx_en_q <= 1'b0;
                    txd_q   <= '0;
                    byte_q  <= '0;
                    dib_q   <= '0;
                end else begin
                    // Outputs carry the dibit of the position just processed.
                    tx_en_q <= (state_q != S_IFG);
                    txd_q   <= dibit;
                    dib_q   <= dib_q + 2'd1;
                    if (dib_q == 2'd3) byte_q <= byte_end ? 16'd0 : byte_q + 16'd1;
                    if (state_q == S_HEADER || state_q == S_PAYLOAD || state_q == S_PAD)
                        crc_q <= crc_dibit(crc_q, dibit);
                    else if (state_q == S_FCS)
                        crc_q <= crc_q >> 2;
                    if (state_q == S_PAYLOAD) begin
                        sh_q     <= eff_sh >> 2;
                        sh_dib_q <= (need_load ? 5'd16 : sh_dib_q) - 5'd1;
                    end
                end
            end
        end
    end

    assign busy       = busy_q;
    assign data_ready = data_ready_q;
    assign underrun   = underrun_q;
    assign txd        = txd_q;
    assign tx_en      = tx_en_q;
endmodule
